// File: rtl/mips_loads_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_loads_if
//  Description : Load-formatter bus: raw memory word, instruction, lanes and
//                rt value in; formatted load result and valid flag out.
//  Revision    : 1.0  initial release
// ============================================================================
interface mips_loads_if;
    logic [31:0] mem_in;
    logic [31:0] instruction;
    logic [3:0]  byteenable;
    logic [31:0] reg_in;
    logic [31:0] mem_out;
    logic        load_valid;

    modport master (
        output mem_in, instruction, byteenable, reg_in,
        input  mem_out, load_valid
    );

    modport slave (
        input  mem_in, instruction, byteenable, reg_in,
        output mem_out, load_valid
    );
endinterface
`default_nettype wire

// File: rtl/mips_loads.sv
`default_nettype none
// ============================================================================
//  Module      : mips_loads
//  Description : Registered MIPS load-data formatter (byte/half extraction,
//                sign/zero extension, LWL/LWR merge), one cycle latency.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_loads (
    input  wire logic     clk,
    input  wire logic     reset,
    mips_loads_if.slave   bus
);

    localparam logic [5:0] c_op_lb  = 6'h20;
    localparam logic [5:0] c_op_lh  = 6'h21;
    localparam logic [5:0] c_op_lwl = 6'h22;
    localparam logic [5:0] c_op_lw  = 6'h23;
    localparam logic [5:0] c_op_lbu = 6'h24;
    localparam logic [5:0] c_op_lhu = 6'h25;
    localparam logic [5:0] c_op_lwr = 6'h26;

    logic [5:0]  w_opcode;
    logic [31:0] w_mem;
    logic [31:0] w_rt;
    logic [7:0]  w_byte;
    logic        w_byte_ok;
    logic [15:0] w_half;
    logic        w_half_ok;
    logic [31:0] w_data;
    logic        w_valid;
    logic [31:0] r_mem_out;
    logic        r_load_valid;

    assign w_opcode = bus.instruction[31:26];
    assign w_mem    = bus.mem_in;
    assign w_rt     = bus.reg_in;

    always_comb begin
        w_byte    = 8'h00;
        w_byte_ok = 1'b1;
        case (bus.byteenable)
            4'b0001: w_byte = w_mem[7:0];
            4'b0010: w_byte = w_mem[15:8];
            4'b0100: w_byte = w_mem[23:16];
            4'b1000: w_byte = w_mem[31:24];
            default: w_byte_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_half    = 16'h0000;
        w_half_ok = 1'b1;
        case (bus.byteenable)
            4'b0011: w_half = w_mem[15:0];
            4'b1100: w_half = w_mem[31:16];
            default: w_half_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_data  = 32'h0000_0000;
        w_valid = 1'b0;
        case (w_opcode)
            c_op_lb: if (w_byte_ok) begin
                w_data  = {{24{w_byte[7]}}, w_byte};
                w_valid = 1'b1;
            end
            c_op_lbu: if (w_byte_ok) begin
                w_data  = {24'h000000, w_byte};
                w_valid = 1'b1;
            end
            c_op_lh: if (w_half_ok) begin
                w_data  = {{16{w_half[15]}}, w_half};
                w_valid = 1'b1;
            end
            c_op_lhu: if (w_half_ok) begin
                w_data  = {16'h0000, w_half};
                w_valid = 1'b1;
            end
            c_op_lw: if (bus.byteenable == 4'b1111) begin
                w_data  = w_mem;
                w_valid = 1'b1;
            end
            // LWL: low bytes of the memory word fill the top of rt
            c_op_lwl: begin
                w_valid = 1'b1;
                case (bus.byteenable)
                    4'b0001: w_data = {w_mem[7:0],  w_rt[23:0]};
                    4'b0011: w_data = {w_mem[15:0], w_rt[15:0]};
                    4'b0111: w_data = {w_mem[23:0], w_rt[7:0]};
                    4'b1111: w_data = w_mem;
                    default: w_valid = 1'b0;
                endcase
            end
            // LWR: high bytes of the memory word fill the bottom of rt
            c_op_lwr: begin
                w_valid = 1'b1;
                case (bus.byteenable)
                    4'b1000: w_data = {w_rt[31:8],  w_mem[31:24]};
                    4'b1100: w_data = {w_rt[31:16], w_mem[31:16]};
                    4'b1110: w_data = {w_rt[31:24], w_mem[31:8]};
                    4'b1111: w_data = w_mem;
                    default: w_valid = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_out    <= 32'h0000_0000;
            r_load_valid <= 1'b0;
        end else begin
            r_mem_out    <= w_data;
            r_load_valid <= w_valid;
        end
    end

    assign bus.mem_out    = r_mem_out;
    assign bus.load_valid = r_load_valid;

endmodule
`default_nettype wire

// File: tb/tb_mips_loads.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_loads
//  Description : Directed vector bench for the mips_loads formatter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_loads;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] mem;
        logic [3:0]  be;
        logic [31:0] rt;
        logic [31:0] exp_out;
        logic        exp_valid;
    } vec_t;

    localparam int c_nvec = 30;

    logic clk;
    logic reset;
    int   r_tests;
    int   r_fails;
    vec_t vecs [c_nvec];

    mips_loads_if bus ();

    mips_loads dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_out, input logic exp_valid);
        r_tests++;
        if (bus.mem_out !== exp_out || bus.load_valid !== exp_valid) begin
            r_fails++;
            $display("FAIL %s: got mem_out=%08h load_valid=%b, want mem_out=%08h load_valid=%b",
                     name, bus.mem_out, bus.load_valid, exp_out, exp_valid);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] mem,
                         input logic [3:0] be, input logic [31:0] rt);
        bus.instruction = instr;
        bus.mem_in      = mem;
        bus.byteenable  = be;
        bus.reg_in      = rt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        r_tests = 0;
        r_fails = 0;

        vecs[0]  = '{"lbu_lane2",     32'h9000_0000, 32'h00FF_00FF, 4'b0100, 32'h0, 32'h0000_00FF, 1'b1};
        vecs[1]  = '{"lb_lane1_neg",  32'h8000_0000, 32'h08E2_F305, 4'b0010, 32'h0, 32'hFFFF_FFF3, 1'b1};
        vecs[2]  = '{"lb_lane0_pos",  32'h8000_0000, 32'h08E2_F305, 4'b0001, 32'h0, 32'h0000_0005, 1'b1};
        vecs[3]  = '{"lw_full",       32'h8C00_0000, 32'h8F4C_29E7, 4'b1111, 32'h0, 32'h8F4C_29E7, 1'b1};
        vecs[4]  = '{"lw_illegal",    32'h8C00_0000, 32'h8F4C_29E7, 4'b0111, 32'h0, 32'h0000_0000, 1'b0};
        vecs[5]  = '{"lh_hi_neg",     32'h8400_0000, 32'h8001_C0DE, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b1};
        vecs[6]  = '{"lhu_hi",        32'h9400_0000, 32'h8001_C0DE, 4'b1100, 32'h0, 32'h0000_8001, 1'b1};
        vecs[7]  = '{"lhu_lo",        32'h9400_0000, 32'h8001_C0DE, 4'b0011, 32'h0, 32'h0000_C0DE, 1'b1};
        vecs[8]  = '{"lwl_0011",      32'h8800_0000, 32'h1122_3344, 4'b0011, 32'hAABB_CCDD, 32'h3344_CCDD, 1'b1};
        vecs[9]  = '{"lwr_1100",      32'h9800_0000, 32'h1122_3344, 4'b1100, 32'hAABB_CCDD, 32'hAABB_1122, 1'b1};
        vecs[10] = '{"op_zero",       32'h0000_0000, 32'h1122_3344, 4'b1111, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[11] = '{"lwl_0001",      32'h8800_0000, 32'h1122_3344, 4'b0001, 32'hAABB_CCDD, 32'h44BB_CCDD, 1'b1};
        vecs[12] = '{"lwl_0111",      32'h8800_0000, 32'h1122_3344, 4'b0111, 32'hAABB_CCDD, 32'h2233_44DD, 1'b1};
        vecs[13] = '{"lwl_1111",      32'h8800_0000, 32'h1122_3344, 4'b1111, 32'hAABB_CCDD, 32'h1122_3344, 1'b1};
        vecs[14] = '{"lwl_illegal",   32'h8800_0000, 32'h1122_3344, 4'b1100, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[15] = '{"lwr_1000",      32'h9800_0000, 32'h1122_3344, 4'b1000, 32'hAABB_CCDD, 32'hAABB_CC11, 1'b1};
        vecs[16] = '{"lwr_1110",      32'h9800_0000, 32'h1122_3344, 4'b1110, 32'hAABB_CCDD, 32'hAA11_2233, 1'b1};
        vecs[17] = '{"lwr_1111",      32'h9800_0000, 32'h1122_3344, 4'b1111, 32'hAABB_CCDD, 32'h1122_3344, 1'b1};
        vecs[18] = '{"lwr_illegal",   32'h9800_0000, 32'h1122_3344, 4'b0001, 32'hAABB_CCDD, 32'h0000_0000, 1'b0};
        vecs[19] = '{"lb_lane3_neg",  32'h8000_0000, 32'h8F4C_29E7, 4'b1000, 32'h0, 32'hFFFF_FF8F, 1'b1};
        vecs[20] = '{"lbu_lane3",     32'h9000_0000, 32'h8F4C_29E7, 4'b1000, 32'h0, 32'h0000_008F, 1'b1};
        vecs[21] = '{"lb_illegal",    32'h8000_0000, 32'h8F4C_29E7, 4'b0011, 32'h0, 32'h0000_0000, 1'b0};
        vecs[22] = '{"lb_no_lanes",   32'h8000_0000, 32'h8F4C_29E7, 4'b0000, 32'h0, 32'h0000_0000, 1'b0};
        vecs[23] = '{"lh_lo_neg",     32'h8400_0000, 32'h8001_C0DE, 4'b0011, 32'h0, 32'hFFFF_C0DE, 1'b1};
        vecs[24] = '{"lh_lo_pos",     32'h8400_0000, 32'h8F4C_29E7, 4'b0011, 32'h0, 32'h0000_29E7, 1'b1};
        vecs[25] = '{"lhu_illegal",   32'h9400_0000, 32'h8001_C0DE, 4'b0110, 32'h0, 32'h0000_0000, 1'b0};
        vecs[26] = '{"lw_low_bits",   32'h8C1F_ABCD, 32'h8F4C_29E7, 4'b1111, 32'h0, 32'h8F4C_29E7, 1'b1};
        vecs[27] = '{"op_0x27",       32'h9C00_0000, 32'h8F4C_29E7, 4'b1111, 32'h0, 32'h0000_0000, 1'b0};
        vecs[28] = '{"lbu_lane1",     32'h9000_0000, 32'h08E2_F305, 4'b0010, 32'h0, 32'h0000_00F3, 1'b1};
        vecs[29] = '{"lh_hi_pos",     32'h8400_0000, 32'h1122_3344, 4'b1100, 32'h0, 32'h0000_1122, 1'b1};

        // Reset dominates a legal LW on the same edge
        reset = 1'b1;
        drive(32'h8C00_0000, 32'hFFFF_FFFF, 4'b1111, 32'hFFFF_FFFF);
        step();
        check("reset_state", 32'h0, 1'b0);
        step();
        check("reset_hold", 32'h0, 1'b0);

        // First edge after release uses the inputs present at that edge
        @(negedge clk);
        reset = 1'b0;
        step();
        check("first_after_reset", 32'hFFFF_FFFF, 1'b1);

        for (int i = 0; i < c_nvec; i++) begin
            @(negedge clk);
            drive(vecs[i].instr, vecs[i].mem, vecs[i].be, vecs[i].rt);
            step();
            check(vecs[i].name, vecs[i].exp_out, vecs[i].exp_valid);
        end

        // Output is registered: a new input must not show before the next edge
        @(negedge clk);
        drive(32'h8C00_0000, 32'h1234_5678, 4'b1111, 32'h0);
        step();
        check("latency_load", 32'h1234_5678, 1'b1);
        @(negedge clk);
        drive(32'h8C00_0000, 32'hCAFE_F00D, 4'b1111, 32'h0);
        #2;
        check("latency_hold", 32'h1234_5678, 1'b1);
        step();
        check("latency_update", 32'hCAFE_F00D, 1'b1);

        // Reset discards a load in flight
        @(negedge clk);
        drive(32'h9000_0000, 32'h00FF_00FF, 4'b0100, 32'h0);
        reset = 1'b1;
        step();
        check("reset_discard", 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check("resume_after_reset", 32'h0000_00FF, 1'b1);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_loads.md
# mips_loads

Registered load-data formatter for the MIPS CPU memory stage. It takes the raw 32-bit word read from data memory, the load instruction and the byte-lane enables. It returns the value to be written to register rt, with byte/halfword extraction, sign/zero extension and LWL/LWR merging applied. Output is registered: one cycle of latency between the memory-read stage and writeback.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_in  input  32  raw word from data memory; lane i = bits [8i+7:8i].
- instruction  input  32  current instruction; opcode = bits [31:26].
- byteenable  input  4  active lanes of mem_in for this access; bit i selects lane i.
- reg_in  input  32  current rt value, used only by LWL/LWR for merging.
- mem_out  output  32  formatted load result (registered).
- load_valid  output  1  registered; 1 when the sampled instruction was a load with a legal byteenable.

## Operation
- Opcode decode:
  - LB = 0x20
  - LH = 0x21
  - LWL = 0x22
  - LW = 0x23
  - LBU = 0x24
  - LHU = 0x25
  - LWR = 0x26
- Any other opcode: next mem_out = 0, load_valid = 0.
- LB/LBU:
  - Legal byteenable is one-hot (0001, 0010, 0100, 1000). Byte = the selected lane.
  - LB sign-extends from bit 7 of the byte; LBU zero-extends.
- LH/LHU:
  - Legal byteenable is 0011 (lanes 0-1) or 1100 (lanes 3-2). Half = the selected lanes, upper lane as the MS byte.
  - LH sign-extends from bit 15; LHU zero-extends.
- LW:
  - Legal byteenable is 1111 only. Result = mem_in unchanged.
- LWL (little-endian, offset k = 0..3):
  - Legal byteenable is 0001, 0011, 0111 or 1111; n = number of set bits = k+1.
  - Result top n bytes = mem_in low n bytes. Result remaining low bytes = reg_in's corresponding low bytes.
  - 1111 gives mem_in.
- LWR (offset k = 0..3):
  - Legal byteenable is 1111, 1110, 1100 or 1000; n = number of set bits.
  - Result low n bytes = mem_in top n bytes. Result remaining high bytes = reg_in's corresponding high bytes.
  - 1111 gives mem_in.
- Illegal byteenable for a recognised load: next mem_out = 0, load_valid = 0.
- Only instruction bits [31:26] are decoded; all other instruction bits are ignored.

## Timing
- Fully synchronous; a single register stage drives mem_out and load_valid.
- Inputs sampled at rising edge N; result visible after edge N until edge N+1. Latency 1 cycle, throughput 1 per cycle, no stall/handshake.
- reset high at an edge: mem_out = 0, load_valid = 0, regardless of other inputs. Reset overrides any load in flight; the sampled load is discarded.
- First edge after reset deasserts: normal operation resumes with the inputs present at that edge.
- The input-to-register path is purely combinational: no combinational path from inputs to outputs, no internal state beyond the output register.

## Test plan
- Reset asserted with mem_in = FFFFFFFF, opcode LW, byteenable 1111 -> after edge mem_out = 00000000, load_valid = 0.
- LBU: mem_in 00FF00FF, instruction 90000000, byteenable 0100 -> next cycle mem_out 000000FF, load_valid 1.
- LB: mem_in 08E2F305, instruction 80000000, byteenable 0010 -> mem_out FFFFFFF3. Same stimulus with byteenable 0001 -> 00000005.
- LW: mem_in 8F4C29E7, instruction 8C000000, byteenable 1111 -> mem_out 8F4C29E7. Same with byteenable 0111 -> mem_out 0, load_valid 0.
- LH/LHU: mem_in 8001C0DE, byteenable 1100 -> LH (84000000) FFFF8001, LHU (94000000) 00008001. Byteenable 0011 with LHU -> 0000C0DE.
- LWL/LWR: reg_in AABBCCDD, mem_in 11223344:
  - LWL (88000000) byteenable 0011 -> 3344CCDD.
  - LWR (98000000) byteenable 1100 -> AABB1122.
  - Opcode 0x00 -> mem_out 0, load_valid 0.
